adc_spi_responder: RTL

//  Peripheral-side model of the LTC2308-style serial ADC that the adc_control master drives over ADC_CONVST/ADC_SCLK/ADC_SDI/ADC_SDO.

---
 rtl/adc_resp_pkg.sv | 31 +++
 rtl/adc_spi_responder_sync.sv | 32 +++
 rtl/adc_spi_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_resp_pkg.sv
// Shared types and constants for the LTC2308-style ADC responder.
// Config word layout is {S/D, O/S, S1, S0, UNI, SLP}.
package adc_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_READY   = 2'd2,
        ST_SHIFT   = 2'd3
    } state_t;

    localparam int SAMPLE_W = 12;
    localparam int CFG_W    = 6;

    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    localparam logic [CFG_W-1:0]    CFG_RESET   = 6'b100010;
    localparam logic [SAMPLE_W-1:0] BIPOLAR_XOR = 12'h800;

    // Bipolar results are the offset-binary sample with the MSB flipped.
    function automatic logic [SAMPLE_W-1:0] to_code(input logic [SAMPLE_W-1:0] sample,
                                                    input logic uni);
        return uni ? sample : (sample ^ BIPOLAR_XOR);
    endfunction

endpackage

// File: rtl/adc_spi_responder_sync.sv
// Multi-flop synchroniser for one asynchronous pin with rise/fall pulses
// derived from the synchronised level.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = sync_r[STAGES-1] & ~prev_r;
    assign fall  = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/adc_spi_responder.sv
// Peripheral-side model of an LTC2308-style serial ADC for loopback/bring-up.
// Optional protocol checking is built when ADC_RESP_PROTO_CHK_EN is defined.
module adc_spi_responder
    import adc_resp_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int CONV_CYCLES = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET,
    input  logic                       ADC_CONVST,
    input  logic                       ADC_SCLK,
    input  logic                       ADC_SDI,
    output logic                       ADC_SDO,
    input  logic [SAMPLE_W*NUM_CH-1:0] SAMPLE_DATA,
    output logic                       BUSY,
    output logic                       PROTO_ERR
);

    localparam int                CNT_W     = $clog2(CONV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CONV_LOAD = CNT_W'(CONV_CYCLES - 1);

    logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
    logic convst_lvl_s, convst_rise_s, convst_fall_s;
    logic sdi_lvl_s, sdi_rise_s, sdi_fall_s;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(CLOCK_50), .rst(RESET), .din(ADC_SCLK),
        .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_convst (
        .clk(CLOCK_50), .rst(RESET), .din(ADC_CONVST),
        .level(convst_lvl_s), .rise(convst_rise_s), .fall(convst_fall_s)
    );
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(CLOCK_50), .rst(RESET), .din(ADC_SDI),
        .level(sdi_lvl_s), .rise(sdi_rise_s), .fall(sdi_fall_s)
    );

    state_t              state_r, state_nxt;
    logic [CNT_W-1:0]    conv_cnt_r, conv_cnt_nxt;
    logic [SAMPLE_W-1:0] result_r, result_nxt;
    logic [CFG_W-1:0]    cfg_r, cfg_nxt;
    logic [CFG_W-1:0]    shadow_r, shadow_nxt;
    logic [2:0]          shadow_cnt_r, shadow_cnt_nxt;
    logic [3:0]          bit_cnt_r, bit_cnt_nxt;
    logic                sdo_r, sdo_nxt;
    logic                busy_r;

    logic [2:0]          chan_s;
    logic [SAMPLE_W-1:0] raw_sample_s, conv_sample_s;
    logic [3:0]          bit_cnt_inc_s, bit_idx_s;
    logic                unused_s;

    // Select the configured channel and apply unipolar/bipolar coding.
    always_comb begin
        chan_s       = 3'(int'({cfg_r[CFG_OS], cfg_r[CFG_S1], cfg_r[CFG_S0]}) % NUM_CH);
        raw_sample_s = 12'h000;
        for (int k = 0; k < NUM_CH; k++) begin
            if (chan_s == 3'(k)) begin
                raw_sample_s = SAMPLE_DATA[k*SAMPLE_W +: SAMPLE_W];
            end else begin
                raw_sample_s = raw_sample_s;
            end
        end
        conv_sample_s = to_code(raw_sample_s, cfg_r[CFG_UNI]);
    end

    // Next-state, counter, shift-register and SDO logic.
    always_comb begin
        state_nxt      = state_r;
        conv_cnt_nxt   = conv_cnt_r;
        result_nxt     = result_r;
        cfg_nxt        = cfg_r;
        shadow_nxt     = shadow_r;
        shadow_cnt_nxt = shadow_cnt_r;
        bit_cnt_nxt    = bit_cnt_r;
        sdo_nxt        = sdo_r;
        bit_cnt_inc_s  = (bit_cnt_r < 4'd12) ? (bit_cnt_r + 4'd1) : 4'd12;
        bit_idx_s      = 4'd11 - bit_cnt_inc_s;

        case (state_r)
            ST_IDLE: begin
                sdo_nxt = 1'b0;
                if (convst_rise_s) begin
                    state_nxt    = ST_CONVERT;
                    conv_cnt_nxt = CONV_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                sdo_nxt = 1'b0;
                // Early read: abort and replay the previous result.
                if (convst_fall_s) begin
                    state_nxt      = ST_SHIFT;
                    sdo_nxt        = result_r[SAMPLE_W-1];
                    bit_cnt_nxt    = 4'd0;
                    shadow_nxt     = 6'b000000;
                    shadow_cnt_nxt = 3'd0;
                end else if (conv_cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt  = ST_READY;
                    result_nxt = conv_sample_s;
                end else begin
                    conv_cnt_nxt = conv_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_READY: begin
                sdo_nxt = 1'b0;
                if (convst_fall_s) begin
                    state_nxt      = ST_SHIFT;
                    sdo_nxt        = result_r[SAMPLE_W-1];
                    bit_cnt_nxt    = 4'd0;
                    shadow_nxt     = 6'b000000;
                    shadow_cnt_nxt = 3'd0;
                end else begin
                    state_nxt = ST_READY;
                end
            end
            ST_SHIFT: begin
                if (convst_rise_s) begin
                    state_nxt      = ST_CONVERT;
                    conv_cnt_nxt   = CONV_LOAD;
                    sdo_nxt        = 1'b0;
                    shadow_cnt_nxt = 3'd0;
                    if (shadow_cnt_r == 3'd6) begin
                        cfg_nxt = shadow_r;
                    end else begin
                        cfg_nxt = cfg_r;
                    end
                end else begin
                    if (sclk_rise_s && (shadow_cnt_r < 3'd6)) begin
                        shadow_nxt     = {shadow_r[CFG_W-2:0], sdi_lvl_s};
                        shadow_cnt_nxt = shadow_cnt_r + 3'd1;
                    end else begin
                        shadow_nxt = shadow_r;
                    end
                    if (sclk_fall_s) begin
                        bit_cnt_nxt = bit_cnt_inc_s;
                        sdo_nxt     = (bit_cnt_inc_s < 4'd12) ? result_r[bit_idx_s] : 1'b0;
                    end else begin
                        bit_cnt_nxt = bit_cnt_r;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                sdo_nxt   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; BUSY is registered from the next state.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_r      <= ST_IDLE;
            conv_cnt_r   <= {CNT_W{1'b0}};
            result_r     <= 12'h000;
            cfg_r        <= CFG_RESET;
            shadow_r     <= 6'b000000;
            shadow_cnt_r <= 3'd0;
            bit_cnt_r    <= 4'd0;
            sdo_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            conv_cnt_r   <= conv_cnt_nxt;
            result_r     <= result_nxt;
            cfg_r        <= cfg_nxt;
            shadow_r     <= shadow_nxt;
            shadow_cnt_r <= shadow_cnt_nxt;
            bit_cnt_r    <= bit_cnt_nxt;
            sdo_r        <= sdo_nxt;
            busy_r       <= (state_nxt == ST_CONVERT);
        end
    end

    assign ADC_SDO = sdo_r;
    assign BUSY    = busy_r;

`ifdef ADC_RESP_PROTO_CHK_EN
    logic err_evt_s;
    logic err_r;

    // Protocol violations: SCLK or early read during CONVERT, partial config word.
    always_comb begin
        err_evt_s = 1'b0;
        if (state_r == ST_CONVERT) begin
            err_evt_s = sclk_rise_s | sclk_fall_s | convst_fall_s;
        end else if (state_r == ST_SHIFT) begin
            err_evt_s = convst_rise_s && (shadow_cnt_r != 3'd0) && (shadow_cnt_r != 3'd6);
        end else begin
            err_evt_s = 1'b0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | err_evt_s;
        end
    end

    assign PROTO_ERR = err_r;
`else
    assign PROTO_ERR = 1'b0;
`endif

    assign unused_s = &{1'b0, cfg_r[CFG_SD], cfg_r[CFG_SLP], sdi_rise_s, sdi_fall_s,
                        sclk_lvl_s, convst_lvl_s};

endmodule
